spi_periph_t: RTL and testbench
===============================

Name: spi_periph_t

Overview:
- Memory-mapped SPI peripheral (responder): the other end of the SoC SPI controller, for linking two boards or looping a master back for test.
- Samples MOSI and drives MISO in mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames, framed by active-low CS.
- CPU side uses the same wen/addr/wdata/rdata bus as the other peripherals, plus a read strobe so that reading the RX FIFO pops it.
- Decoded at 0x10000500 -> 0x100005ff.

Parameters:
- RX_DEPTH, 4, RX FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- wen  input  1  write strobe (sel & is_write)
- ren  input  1  one-cycle read strobe (sel & is_read); qualifies FIFO pop only
- addr  input  32  byte address; only addr[7:0] decoded
- wdata  input  32  write data
- rdata  output  32  registered read data
- sck  input  1  SPI clock from master (asynchronous)
- cs  input  1  chip select, active low (asynchronous)
- mosi  input  1  master out (asynchronous)
- miso  output  1  responder out
- miso_oe  output  1  MISO output enable (1 while selected)

Behaviour:
- Reset values: rdata=0, miso=1, miso_oe=0, FIFO empty, TX holding empty, all flags 0, bit count 0. Synchronisers reset to idle: sck=0, cs=1, mosi=1.
- Register map:
  - 0x00 TX: write loads the TX holding register from wdata[7:0] and sets tx_full; read returns the holding byte.
  - 0x04 RX: read returns the FIFO head (0 if empty); ren pops when non-empty.
  - 0x08 STATUS: bit0 rx_valid (FIFO non-empty), bit1 rx_overrun (sticky), bit2 tx_empty, bit3 busy (cs_s low), bit4 tx_underrun (sticky), bits[7:5] bit count. Write: wdata bit1/bit4 = 1 clears the matching sticky flag.
  - 0x0C: read returns FIFO occupancy.
  - Other offsets read 0; writes to other offsets are ignored.
- Read latency: rdata registered every cycle from addr[7:0] when wen=0; valid the cycle after addr is presented.
- Synchronisation: sck, cs and mosi each pass through 2 flops (sck_s, cs_s, mosi_s), plus one delay flop on sck_s/cs_s for edge detect. Edge-to-action latency is 3 clk.
- Master SCK half-period must be >= 4 clk. Below that, behaviour is undefined.
- cs_s falling edge:
  - bit count=0, miso_oe=1.
  - Load srout from holding if tx_full (clear tx_full); otherwise load 0xFF and set tx_underrun.
  - miso=srout[7].
- sck_s rising edge (cs_s low): srin={srin[6:0],mosi_s}; count++.
  - When count reaches 8: push srin into FIFO and set count=0.
  - If the FIFO is full, drop the byte and set rx_overrun; FIFO contents are unchanged.
- sck_s falling edge (cs_s low):
  - If count==0 (byte boundary): reload srout from holding or 0xFF/underrun, exactly as on cs fall.
  - Otherwise: srout={srout[6:0],1}.
  - miso=new srout[7]. MISO therefore settles <=3 clk after the SCK fall, before the master's next sampling edge.
- cs_s rising edge:
  - Partial byte discarded (no push); count=0.
  - miso_oe=0, miso=1. The holding register is untouched.
- Edges of sck_s while cs_s is high are ignored.
- Simultaneous events:
  - Holding load and CPU TX write in the same cycle: the shifter takes the old value, the new value is stored, tx_full stays 1.
  - CPU TX write while already full: overwrites.
  - Push and pop in the same cycle: both occur, occupancy unchanged. Push to a full FIFO is allowed if a pop occurs in the same cycle.
  - Sticky set and clear in the same cycle: set wins.
- FIFO pointers are log2(RX_DEPTH)+1 bits and wrap naturally; full/empty are taken from the MSB comparison.
- Asynchronous reset mid-frame: immediate return to reset state. The frame is lost; after reset the block waits for the next cs fall.

Decomposition:
- Shared package constants:
  - register offsets: SPI_P_TX=0x00, SPI_P_RX=0x04, SPI_P_STATUS=0x08, SPI_P_LEVEL=0x0C
  - status bit indices
  - idle fill byte 0xFF
- One sub-module: sync_fifo_t (WIDTH=8, DEPTH=RX_DEPTH; push/pop/full/empty/level, async reset), reusable for a future UART FIFO. The synchronisers stay inline.

Test Plan:
- Reset with cs=1 -> miso=1, miso_oe=0; STATUS read = 0x04 (tx_empty only).
- Write TX=0xA5, master (half-period 6 clk) sends 0x3C -> master receives 0xA5; STATUS bit0=1; read RX = 0x3C; then STATUS bit0=0 and tx_empty=1.
- Three-byte burst in one CS, TX refilled with 0x11, 0x22 after each byte -> master receives A5,11,22. Start a fourth byte with TX empty -> master receives 0xFF and tx_underrun=1; write 0x10 to STATUS -> tx_underrun=0.
- Master sends 5 bytes, CPU does not read (RX_DEPTH=4) -> level=4, rx_overrun=1; RX reads return bytes 1-4 in order, byte 5 lost.
- CS deasserted after 5 SCK rises, then a full byte 0x81 is sent -> only 0x81 is pushed, level=1; miso_oe falls within 3 clk of the CS rise.
- Assert reset mid-byte with FIFO holding 2 entries -> level=0, flags clear, miso=1 asynchronously. A following frame of 0x7E is received correctly.

Source files
------------

// File: rtl/spi_periph_t_pkg.sv
// Shared constants for the memory-mapped SPI responder: register offsets,
// STATUS bit positions, the idle fill byte and the STATUS packing helper.
package spi_periph_t_pkg;

    localparam logic [7:0] SPI_P_TX     = 8'h00;
    localparam logic [7:0] SPI_P_RX     = 8'h04;
    localparam logic [7:0] SPI_P_STATUS = 8'h08;
    localparam logic [7:0] SPI_P_LEVEL  = 8'h0C;

    localparam int STAT_RX_VALID   = 0;
    localparam int STAT_RX_OVERRUN = 1;
    localparam int STAT_TX_EMPTY   = 2;
    localparam int STAT_BUSY       = 3;
    localparam int STAT_TX_UNDER   = 4;

    // Byte shifted out when the CPU has not supplied one in time
    localparam logic [7:0] SPI_IDLE_FILL = 8'hFF;

    // Assemble the low byte of the STATUS register
    function automatic logic [7:0] pack_status(input logic [2:0] bit_cnt,
                                               input logic       tx_under,
                                               input logic       busy,
                                               input logic       tx_empty,
                                               input logic       rx_overrun,
                                               input logic       rx_valid);
        logic [7:0] s;
        s                  = 8'h00;
        s[7:5]             = bit_cnt;
        s[STAT_TX_UNDER]   = tx_under;
        s[STAT_BUSY]       = busy;
        s[STAT_TX_EMPTY]   = tx_empty;
        s[STAT_RX_OVERRUN] = rx_overrun;
        s[STAT_RX_VALID]   = rx_valid;
        return s;
    endfunction

endpackage

// File: rtl/spi_periph_t_fifo.sv
// Small synchronous FIFO with async reset. Pointers carry one extra wrap bit
// so full/empty fall out of an MSB comparison. Head is read combinationally.
module sync_fifo_t #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level_o   = wr_q - rd_q;
    assign rdata_o   = mem_q[rd_q[AW-1:0]];
    // A push into a full FIFO is accepted only when a pop frees the slot this cycle
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);

    // Storage and pointer update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_q[AW-1:0]] <= wdata_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (do_pop_s) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_periph_t.sv
// SPI responder, mode 0, MSB first, 8-bit frames. SCK/CS/MOSI are
// synchronised into clk; all shifting happens on detected edges of the
// synchronised SCK, so the master half-period must cover the 3-clk latency.
module spi_periph_t
    import spi_periph_t_pkg::*;
#(
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wen,
    input  logic        ren,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        sck,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe
);
    localparam int LW = $clog2(RX_DEPTH) + 1;

    logic sck_m_q, sck_s_q, sck_dly_q;
    logic cs_m_q, cs_s_q, cs_dly_q;
    logic mosi_m_q, mosi_s_q;

    logic [7:0]  hold_q, hold_d;
    logic        tx_full_q, tx_full_d;
    logic [7:0]  srout_q, srout_d;
    logic [7:0]  srin_q, srin_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic        ovr_q, ovr_d;
    logic        und_q, und_d;
    logic [31:0] rdata_q, rdata_d;

    logic        sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s;
    logic        load_s, push_req_s, push_s, pop_s, overrun_set_s;
    logic [7:0]  load_byte_s, rx_byte_s, head_s;
    logic        fifo_full_s, fifo_empty_s;
    logic [LW-1:0] level_s;
    logic [7:0]  status_s;
    logic        unused_ok_s;

    assign unused_ok_s = ^{addr[31:8], wdata[31:8]};

    // Two-flop synchronisers plus a delay flop for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_m_q  <= 1'b0; sck_s_q  <= 1'b0; sck_dly_q <= 1'b0;
            cs_m_q   <= 1'b1; cs_s_q   <= 1'b1; cs_dly_q  <= 1'b1;
            mosi_m_q <= 1'b1; mosi_s_q <= 1'b1;
        end else begin
            sck_m_q  <= sck;  sck_s_q  <= sck_m_q;  sck_dly_q <= sck_s_q;
            cs_m_q   <= cs;   cs_s_q   <= cs_m_q;   cs_dly_q  <= cs_s_q;
            mosi_m_q <= mosi; mosi_s_q <= mosi_m_q;
        end
    end

    assign sck_rise_s  = sck_s_q & ~sck_dly_q & ~cs_s_q;
    assign sck_fall_s  = ~sck_s_q & sck_dly_q & ~cs_s_q;
    assign cs_fall_s   = ~cs_s_q & cs_dly_q;
    assign cs_rise_s   = cs_s_q & ~cs_dly_q;
    // Holding reloads at frame start and at every byte boundary
    assign load_s      = cs_fall_s | (sck_fall_s & (cnt_q == 3'd0));
    assign load_byte_s = tx_full_q ? hold_q : SPI_IDLE_FILL;
    assign rx_byte_s   = {srin_q[6:0], mosi_s_q};
    assign push_req_s  = sck_rise_s & (cnt_q == 3'd7);
    assign pop_s       = ren & ~wen & (addr[7:0] == SPI_P_RX) & ~fifo_empty_s;
    assign push_s      = push_req_s & (~fifo_full_s | pop_s);
    assign overrun_set_s = push_req_s & fifo_full_s & ~pop_s;
    assign status_s    = pack_status(cnt_q, und_q, ~cs_s_q, ~tx_full_q, ovr_q, ~fifo_empty_s);

    sync_fifo_t #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (rx_byte_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (level_s)
    );

    // Next-state for shifters, flags, TX holding and the read mux
    always_comb begin
        hold_d    = hold_q;
        tx_full_d = tx_full_q;
        srout_d   = srout_q;
        srin_d    = srin_q;
        cnt_d     = cnt_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        ovr_d     = ovr_q;
        und_d     = und_q;
        rdata_d   = rdata_q;

        if (cs_fall_s) begin
            cnt_d = 3'd0;
            oe_d  = 1'b1;
        end else if (cs_rise_s) begin
            cnt_d = 3'd0;
            oe_d  = 1'b0;
        end else if (sck_rise_s) begin
            srin_d = rx_byte_s;
            cnt_d  = cnt_q + 3'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (cs_rise_s) begin
            miso_d = 1'b1;
        end else if (load_s) begin
            srout_d   = load_byte_s;
            tx_full_d = 1'b0;
            miso_d    = load_byte_s[7];
        end else if (sck_fall_s) begin
            srout_d = {srout_q[6:0], 1'b1};
            miso_d  = srout_q[6];
        end else begin
            miso_d = miso_q;
        end

        // CPU write after the load so a same-cycle write is kept and tx_full stays set
        if (wen) begin
            case (addr[7:0])
                SPI_P_TX: begin
                    hold_d    = wdata[7:0];
                    tx_full_d = 1'b1;
                end
                SPI_P_STATUS: begin
                    if (wdata[STAT_RX_OVERRUN]) ovr_d = 1'b0; else ovr_d = ovr_q;
                    if (wdata[STAT_TX_UNDER])   und_d = 1'b0; else und_d = und_q;
                end
                default: begin
                    hold_d = hold_q;
                end
            endcase
        end else begin
            case (addr[7:0])
                SPI_P_TX:     rdata_d = {24'h000000, hold_q};
                SPI_P_RX:     rdata_d = fifo_empty_s ? 32'h0000_0000 : {24'h000000, head_s};
                SPI_P_STATUS: rdata_d = {24'h000000, status_s};
                SPI_P_LEVEL:  rdata_d = {{(32-LW){1'b0}}, level_s};
                default:      rdata_d = 32'h0000_0000;
            endcase
        end

        // Sticky sets last so they win over a same-cycle clear
        if (overrun_set_s) ovr_d = 1'b1; else ovr_d = ovr_d;
        if (load_s && !tx_full_q) und_d = 1'b1; else und_d = und_d;
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q    <= 8'h00;
            tx_full_q <= 1'b0;
            srout_q   <= 8'hFF;
            srin_q    <= 8'h00;
            cnt_q     <= 3'd0;
            miso_q    <= 1'b1;
            oe_q      <= 1'b0;
            ovr_q     <= 1'b0;
            und_q     <= 1'b0;
            rdata_q   <= 32'h0000_0000;
        end else begin
            hold_q    <= hold_d;
            tx_full_q <= tx_full_d;
            srout_q   <= srout_d;
            srin_q    <= srin_d;
            cnt_q     <= cnt_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            ovr_q     <= ovr_d;
            und_q     <= und_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata   = rdata_q;
    assign miso    = miso_q;
    assign miso_oe = oe_q;

endmodule

// File: tb/tb_spi_periph_t.sv
// Directed bench for spi_periph_t: a register-access vector table, then
// hand-written SPI master sequences (half-period 6 clk) for framing corners.
module tb_spi_periph_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wen = 1'b0, ren = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [31:0] rdata;
    logic        sck = 1'b0, cs = 1'b1, mosi = 1'b1;
    logic        miso, miso_oe;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A_TX = 32'h1000_0500, A_RX = 32'h1000_0504;
    localparam logic [31:0] A_ST = 32'h1000_0508, A_LV = 32'h1000_050C;

    spi_periph_t #(.RX_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .wen(wen), .ren(ren), .addr(addr),
        .wdata(wdata), .rdata(rdata), .sck(sck), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] wd;
        logic        wr;
        logic        pop;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic pop, output logic [31:0] d);
        addr = a; ren = pop;
        @(negedge clk);
        ren = 1'b0;
        d = rdata;
    endtask

    task automatic read_chk(input string nm, input logic [31:0] a, input logic pop,
                            input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, pop, d);
        chk(nm, d, exp);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        wait_clk(6);
    endtask

    // One mode-0 byte: data set while SCK low, MISO sampled at the rise
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            wait_clk(6);
            sck = 1'b1;
            rx[i] = miso;
            wait_clk(6);
            sck = 1'b0;
        end
        wait_clk(6);
    endtask

    task automatic xfer_chk(input string nm, input logic [7:0] tx, input logic [7:0] exp);
        logic [7:0] rx;
        xfer(tx, rx);
        chk(nm, {24'h0, rx}, {24'h0, exp});
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  rx;

        vecs[0] = '{"rst_status",  A_ST,          32'h0, 1'b0, 1'b0, 32'h04};
        vecs[1] = '{"wr_tx",       A_TX,          32'hFFFF_FFA5, 1'b1, 1'b0, 32'h0};
        vecs[2] = '{"rd_tx",       A_TX,          32'h0, 1'b0, 1'b0, 32'hA5};
        vecs[3] = '{"status_full", A_ST,          32'h0, 1'b0, 1'b0, 32'h00};
        vecs[4] = '{"rx_empty",    A_RX,          32'h0, 1'b0, 1'b1, 32'h00};
        vecs[5] = '{"level0",      A_LV,          32'h0, 1'b0, 1'b0, 32'h00};
        vecs[6] = '{"unmapped",    32'h1000_0510, 32'h0, 1'b0, 1'b0, 32'h00};
        vecs[7] = '{"wr_unmapped", 32'h1000_0510, 32'h5A, 1'b1, 1'b0, 32'h0};
        vecs[8] = '{"wr_st_noop",  A_ST,          32'h12, 1'b1, 1'b0, 32'h0};
        vecs[9] = '{"status_keep", A_ST,          32'h0, 1'b0, 1'b0, 32'h00};

        wait_clk(3);
        chk("rst_miso", {31'h0, miso}, 32'h1);
        chk("rst_oe", {31'h0, miso_oe}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        reset = 1'b0;
        wait_clk(4);

        // Register map vectors; leaves TX=0xA5 loaded
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].a, vecs[i].wd);
            end else begin
                read_chk(vecs[i].name, vecs[i].a, vecs[i].pop, vecs[i].exp);
            end
        end

        // Single byte: responder sends A5, master sends 3C
        cs_low();
        chk("t1_miso_msb", {31'h0, miso}, 32'h1);
        chk("t1_oe", {31'h0, miso_oe}, 32'h1);
        read_chk("t1_busy", A_ST, 1'b0, 32'h0C);
        xfer_chk("t1_master_rx", 8'h3C, 8'hA5);
        cs_high();
        read_chk("t1_status", A_ST, 1'b0, 32'h15);
        read_chk("t1_rx", A_RX, 1'b1, 32'h3C);
        read_chk("t1_status2", A_ST, 1'b0, 32'h14);
        bus_write(A_ST, 32'h10);
        read_chk("t1_clr_und", A_ST, 1'b0, 32'h04);

        // Burst with refills, fourth byte underruns
        bus_write(A_TX, 32'hA5);
        cs_low();
        bus_write(A_TX, 32'h11);
        xfer_chk("b_byte1", 8'h01, 8'hA5);
        bus_write(A_TX, 32'h22);
        xfer_chk("b_byte2", 8'h02, 8'h11);
        xfer_chk("b_byte3", 8'h03, 8'h22);
        xfer_chk("b_byte4", 8'h04, 8'hFF);
        cs_high();
        read_chk("b_status", A_ST, 1'b0, 32'h15);
        read_chk("b_level", A_LV, 1'b0, 32'h4);
        bus_write(A_ST, 32'h10);
        read_chk("b_clr_und", A_ST, 1'b0, 32'h05);
        for (int i = 1; i <= 4; i++) begin
            read_chk("b_drain", A_RX, 1'b1, i);
        end

        // Overrun: five bytes, no CPU reads
        cs_low();
        for (int i = 1; i <= 5; i++) begin
            xfer(8'(i * 16), rx);
        end
        cs_high();
        read_chk("o_level", A_LV, 1'b0, 32'h4);
        read_chk("o_status", A_ST, 1'b0, 32'h17);
        for (int i = 1; i <= 4; i++) begin
            read_chk("o_rx", A_RX, 1'b1, i * 16);
        end
        read_chk("o_rx_empty", A_RX, 1'b1, 32'h0);
        read_chk("o_level0", A_LV, 1'b0, 32'h0);
        bus_write(A_ST, 32'h12);
        read_chk("o_clr", A_ST, 1'b0, 32'h04);

        // Partial byte discarded on CS rise
        cs_low();
        for (int i = 0; i < 5; i++) begin
            mosi = 1'b1;
            wait_clk(6);
            sck = 1'b1;
            wait_clk(6);
            sck = 1'b0;
        end
        wait_clk(6);
        read_chk("p_count5", A_ST, 1'b0, 32'hBC);
        cs = 1'b1;
        wait_clk(2);
        chk("p_oe_hold", {31'h0, miso_oe}, 32'h1);
        wait_clk(1);
        chk("p_oe_fall", {31'h0, miso_oe}, 32'h0);
        chk("p_miso_idle", {31'h0, miso}, 32'h1);
        wait_clk(6);
        read_chk("p_level0", A_LV, 1'b0, 32'h0);
        cs_low();
        xfer(8'h81, rx);
        cs_high();
        read_chk("p_level1", A_LV, 1'b0, 32'h1);
        read_chk("p_rx", A_RX, 1'b1, 32'h81);
        bus_write(A_ST, 32'h12);

        // Async reset mid-byte with two entries in the FIFO
        bus_write(A_TX, 32'h00);
        cs_low();
        bus_write(A_TX, 32'h00);
        xfer_chk("r_byte1", 8'hAA, 8'h00);
        bus_write(A_TX, 32'h00);
        xfer_chk("r_byte2", 8'hBB, 8'h00);
        read_chk("r_level2", A_LV, 1'b0, 32'h2);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b0;
            wait_clk(6);
            sck = 1'b1;
            wait_clk(6);
            sck = 1'b0;
        end
        wait_clk(6);
        chk("r_miso_pre", {31'h0, miso}, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("r_miso_async", {31'h0, miso}, 32'h1);
        chk("r_oe_async", {31'h0, miso_oe}, 32'h0);
        chk("r_rdata_async", rdata, 32'h0);
        cs = 1'b1;
        mosi = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(4);
        read_chk("r_status", A_ST, 1'b0, 32'h04);
        read_chk("r_level0", A_LV, 1'b0, 32'h0);
        cs_low();
        xfer_chk("r_post_tx", 8'h7E, 8'hFF);
        cs_high();
        read_chk("r_post_level", A_LV, 1'b0, 32'h1);
        read_chk("r_post_rx", A_RX, 1'b1, 32'h7E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
